// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I decode definitions used by decode_stage and imm_gen:
//     - OPC_* : 7-bit major opcodes (instr[6:0])
//     - alu_op_e : operation selector sent to execute (5 bits)
//     - imm_fmt_e : immediate encoding format chosen by the decoder
//     - ctrl_t : bundle of control bits produced by the decoder
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_OR     = 5'd7,
        ALU_AND    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src_imm;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
//   Combinational immediate extraction for the RV32I base formats.
//   Ports:
//     instr   in  32  instruction word
//     imm_fmt in  3   format selected by the decoder (imm_fmt_e)
//     imm     out 32  sign-extended immediate (0 for IMM_NONE)
// -----------------------------------------------------------------------------
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_e    imm_fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (imm_fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'd0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I decode / operand-fetch stage with a single ID/EX pipeline register.
//   Optional feature macro: DECODE_RV32M_EN (decode OP funct7=0000001 as M ops;
//   when undefined that encoding is flagged illegal).
//   Ports:
//     clk, rst              clock / synchronous active-high reset
//     flush                 squash held and incoming instruction
//     if_valid/if_ready     fetch handshake; if_pc, if_instr payload
//     rf_raddr1/2           register-file read addresses (combinational)
//     rf_rdata1/2           register-file read data (combinational return)
//     wb_we/wb_addr/wb_data writeback port, bypassed into operands
//     id_valid/id_ready     ID/EX handshake towards execute
//     id_*                  registered decoded instruction
// -----------------------------------------------------------------------------
module decode_stage
    import riscv_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_alu_op,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_branch,
    output logic            id_jump,
    output logic            id_alu_src_imm,
    output logic            id_illegal
);

    // ---------------- instruction fields ----------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode    = if_instr[6:0];
    assign funct3    = if_instr[14:12];
    assign funct7    = if_instr[31:25];
    assign rf_raddr1 = if_instr[19:15];
    assign rf_raddr2 = if_instr[24:20];

    // ---------------- pipeline register state ----------------
    logic            id_valid_q,   id_valid_d;
    logic [XLEN-1:0] id_pc_q,      id_pc_d;
    logic [4:0]      id_rs1_q,     id_rs1_d;
    logic [4:0]      id_rs2_q,     id_rs2_d;
    logic [XLEN-1:0] id_rs1_val_q, id_rs1_val_d;
    logic [XLEN-1:0] id_rs2_val_q, id_rs2_val_d;
    logic [XLEN-1:0] id_imm_q,     id_imm_d;
    logic [4:0]      id_rd_q,      id_rd_d;
    alu_op_e         id_alu_op_q,  id_alu_op_d;
    ctrl_t           id_ctrl_q,    id_ctrl_d;

    // ---------------- operand select and hold refresh ----------------
    logic [4:0]      rs_idx   [2];
    logic [4:0]      held_rs  [2];
    logic [XLEN-1:0] rf_rdata [2];
    logic [XLEN-1:0] op_val   [2];
    logic            refresh  [2];

    assign rs_idx[0]   = rf_raddr1;
    assign rs_idx[1]   = rf_raddr2;
    assign held_rs[0]  = id_rs1_q;
    assign held_rs[1]  = id_rs2_q;
    assign rf_rdata[0] = rf_rdata1;
    assign rf_rdata[1] = rf_rdata2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        // x0 reads as zero; a same-cycle writeback beats the (stale) RF read.
        assign op_val[gi]  = (rs_idx[gi] == 5'd0)                  ? '0 :
                             (wb_we && (wb_addr == rs_idx[gi]))    ? wb_data :
                                                                     rf_rdata[gi];
        // A stalled instruction must still observe writebacks to its sources.
        assign refresh[gi] = id_valid_q && !id_ready && wb_we &&
                             (wb_addr != 5'd0) && (wb_addr == held_rs[gi]);
    end

    // ---------------- decoder ----------------
    imm_fmt_e        imm_fmt;
    alu_op_e         dec_alu_op;
    ctrl_t           dec_ctrl;
    logic [4:0]      dec_rd;
    logic            legal;
    logic [31:0]     imm32;

    imm_gen u_imm_gen (
        .instr   (if_instr),
        .imm_fmt (imm_fmt),
        .imm     (imm32)
    );

    always_comb begin
        imm_fmt    = IMM_NONE;
        dec_alu_op = ALU_ADD;
        dec_ctrl   = '0;
        dec_rd     = if_instr[11:7];
        legal      = 1'b1;

        case (opcode)
            OPC_LOAD: begin
                imm_fmt              = IMM_I;
                dec_ctrl.reg_write   = 1'b1;
                dec_ctrl.mem_read    = 1'b1;
                dec_ctrl.alu_src_imm = 1'b1;
                // LB LH LW LBU LHU only
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                imm_fmt              = IMM_S;
                dec_ctrl.mem_write   = 1'b1;
                dec_ctrl.alu_src_imm = 1'b1;
                dec_rd               = 5'd0;
                legal = !funct3[2] && (funct3[1:0] != 2'b11);
            end
            OPC_BRANCH: begin
                imm_fmt         = IMM_B;
                dec_ctrl.branch = 1'b1;
                dec_rd          = 5'd0;
                legal           = (funct3[2:1] != 2'b01);
                // BEQ/BNE compare by subtraction, BLT/BGE and BLTU/BGEU by set-less-than
                dec_alu_op = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
            end
            OPC_JAL: begin
                imm_fmt            = IMM_J;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            OPC_JALR: begin
                imm_fmt            = IMM_I;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                legal              = (funct3 == 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_fmt              = IMM_U;
                dec_ctrl.reg_write   = 1'b1;
                dec_ctrl.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_fmt              = IMM_I;
                dec_ctrl.reg_write   = 1'b1;
                dec_ctrl.alu_src_imm = 1'b1;
                case (funct3)
                    3'b000: dec_alu_op = ALU_ADD;
                    3'b010: dec_alu_op = ALU_SLT;
                    3'b011: dec_alu_op = ALU_SLTU;
                    3'b100: dec_alu_op = ALU_XOR;
                    3'b110: dec_alu_op = ALU_OR;
                    3'b111: dec_alu_op = ALU_AND;
                    3'b001: begin
                        dec_alu_op = ALU_SLL;
                        legal      = (funct7 == 7'b0000000);
                    end
                    default: begin
                        dec_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        legal      = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                dec_ctrl.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_alu_op = ALU_ADD;
                        3'b001:  dec_alu_op = ALU_SLL;
                        3'b010:  dec_alu_op = ALU_SLT;
                        3'b011:  dec_alu_op = ALU_SLTU;
                        3'b100:  dec_alu_op = ALU_XOR;
                        3'b101:  dec_alu_op = ALU_SRL;
                        3'b110:  dec_alu_op = ALU_OR;
                        default: dec_alu_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        dec_alu_op = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_alu_op = ALU_SRA;
                    end else begin
                        legal = 1'b0;
                    end
                end else if (funct7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
                    case (funct3)
                        3'b000:  dec_alu_op = ALU_MUL;
                        3'b001:  dec_alu_op = ALU_MULH;
                        3'b010:  dec_alu_op = ALU_MULHSU;
                        3'b011:  dec_alu_op = ALU_MULHU;
                        3'b100:  dec_alu_op = ALU_DIV;
                        3'b101:  dec_alu_op = ALU_DIVU;
                        3'b110:  dec_alu_op = ALU_REM;
                        default: dec_alu_op = ALU_REMU;
                    endcase
`else
                    legal = 1'b0;
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_FENCE: begin
                // FENCE and FENCE.I execute as no-ops in this pipeline
                legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            OPC_SYSTEM: begin
                legal = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        if (if_instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end
        if (dec_rd == 5'd0) begin
            dec_ctrl.reg_write = 1'b0;
        end
        if (!legal) begin
            dec_ctrl.reg_write = 1'b0;
            dec_ctrl.mem_read  = 1'b0;
            dec_ctrl.mem_write = 1'b0;
            dec_ctrl.branch    = 1'b0;
            dec_ctrl.jump      = 1'b0;
            dec_ctrl.illegal   = 1'b1;
        end
    end

    // ---------------- next-state for the ID/EX register ----------------
    logic capture;

    assign if_ready = !id_valid_q || id_ready;
    assign capture  = if_valid && if_ready;

    always_comb begin
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_rs1_d     = id_rs1_q;
        id_rs2_d     = id_rs2_q;
        id_rs1_val_d = id_rs1_val_q;
        id_rs2_val_d = id_rs2_val_q;
        id_imm_d     = id_imm_q;
        id_rd_d      = id_rd_q;
        id_alu_op_d  = id_alu_op_q;
        id_ctrl_d    = id_ctrl_q;

        if (flush) begin
            id_valid_d = 1'b0;
        end else if (capture) begin
            id_valid_d = 1'b1;
        end else if (id_ready) begin
            id_valid_d = 1'b0;
        end

        if (capture && !flush) begin
            id_pc_d      = if_pc;
            id_rs1_d     = rf_raddr1;
            id_rs2_d     = rf_raddr2;
            id_rs1_val_d = op_val[0];
            id_rs2_val_d = op_val[1];
            id_imm_d     = XLEN'($signed(imm32));
            id_rd_d      = dec_rd;
            id_alu_op_d  = dec_alu_op;
            id_ctrl_d    = dec_ctrl;
        end else begin
            if (refresh[0]) begin
                id_rs1_val_d = wb_data;
            end
            if (refresh[1]) begin
                id_rs2_val_d = wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q   <= 1'b0;
            id_pc_q      <= RESET_PC;
            id_rs1_q     <= '0;
            id_rs2_q     <= '0;
            id_rs1_val_q <= '0;
            id_rs2_val_q <= '0;
            id_imm_q     <= '0;
            id_rd_q      <= '0;
            id_alu_op_q  <= ALU_ADD;
            id_ctrl_q    <= '0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_rs1_q     <= id_rs1_d;
            id_rs2_q     <= id_rs2_d;
            id_rs1_val_q <= id_rs1_val_d;
            id_rs2_val_q <= id_rs2_val_d;
            id_imm_q     <= id_imm_d;
            id_rd_q      <= id_rd_d;
            id_alu_op_q  <= id_alu_op_d;
            id_ctrl_q    <= id_ctrl_d;
        end
    end

    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_rs1         = id_rs1_q;
    assign id_rs2         = id_rs2_q;
    assign id_rs1_val     = id_rs1_val_q;
    assign id_rs2_val     = id_rs2_val_q;
    assign id_imm         = id_imm_q;
    assign id_rd          = id_rd_q;
    assign id_alu_op      = id_alu_op_q;
    assign id_reg_write   = id_ctrl_q.reg_write;
    assign id_mem_read    = id_ctrl_q.mem_read;
    assign id_mem_write   = id_ctrl_q.mem_write;
    assign id_branch      = id_ctrl_q.branch;
    assign id_jump        = id_ctrl_q.jump;
    assign id_alu_src_imm = id_ctrl_q.alu_src_imm;
    assign id_illegal     = id_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, if_ready;
    logic [31:0] if_pc, if_instr;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_op;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
    logic        id_alu_src_imm, id_illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump), .id_alu_src_imm(id_alu_src_imm),
        .id_illegal(id_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wbwe;
        logic [4:0]  wbaddr;
        logic [31:0] wbdata;
        logic [31:0] e_rs1v;
        logic [31:0] e_rs2v;
        logic [31:0] e_imm;
        logic [4:0]  e_rd;
        logic [4:0]  e_op;
        logic        chk_op;
        logic [6:0]  e_ctrl;   // {reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal}
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [13];
    vec_t sb_q [$];

    function automatic vec_t mk(input logic [31:0] pc, instr, rd1, rd2,
                                input logic wbwe, input logic [4:0] wbaddr, input logic [31:0] wbdata,
                                input logic [31:0] e_rs1v, e_rs2v, e_imm,
                                input logic [4:0] e_rd, input alu_op_e e_op, input logic chk_op,
                                input logic [6:0] e_ctrl);
        vec_t v;
        v.pc = pc; v.instr = instr; v.rd1 = rd1; v.rd2 = rd2;
        v.wbwe = wbwe; v.wbaddr = wbaddr; v.wbdata = wbdata;
        v.e_rs1v = e_rs1v; v.e_rs2v = e_rs2v; v.e_imm = e_imm;
        v.e_rd = e_rd; v.e_op = e_op; v.chk_op = chk_op; v.e_ctrl = e_ctrl;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src_imm, id_illegal};
    endfunction

    // Pop the oldest expected record and compare it to the ID/EX outputs.
    task automatic check_head(input string tag);
        vec_t e;
        logic [31:0] iw;
        if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty while id_valid=%0b", tag, id_valid);
            return;
        end
        e  = sb_q.pop_front();
        iw = e.instr;
        cmp({tag, ".valid"}, {31'd0, id_valid}, 32'd1);
        cmp({tag, ".pc"}, id_pc, e.pc);
        cmp({tag, ".rs1"}, {27'd0, id_rs1}, {27'd0, iw[19:15]});
        cmp({tag, ".rs2"}, {27'd0, id_rs2}, {27'd0, iw[24:20]});
        cmp({tag, ".rs1_val"}, id_rs1_val, e.e_rs1v);
        cmp({tag, ".rs2_val"}, id_rs2_val, e.e_rs2v);
        cmp({tag, ".imm"}, id_imm, e.e_imm);
        cmp({tag, ".rd"}, {27'd0, id_rd}, {27'd0, e.e_rd});
        if (e.chk_op) cmp({tag, ".alu_op"}, {27'd0, id_alu_op}, {27'd0, e.e_op});
        cmp({tag, ".ctrl"}, {25'd0, ctrl_now()}, {25'd0, e.e_ctrl});
        $display("[TB] %s pc=0x%08h instr=0x%08h imm=0x%08h rd=%0d ctrl=%07b",
                 tag, id_pc, e.instr, id_imm, id_rd, ctrl_now());
    endtask

    // Drive one record for one cycle; push it on the scoreboard if it is accepted.
    task automatic drive(input vec_t v, input logic do_flush);
        logic [31:0] iw;
        iw        = v.instr;
        if_valid  = 1'b1; if_pc = v.pc; if_instr = v.instr;
        rf_rdata1 = v.rd1; rf_rdata2 = v.rd2;
        wb_we     = v.wbwe; wb_addr = v.wbaddr; wb_data = v.wbdata;
        flush     = do_flush;
        #1;
        cmp("raddr1", {27'd0, rf_raddr1}, {27'd0, iw[19:15]});
        cmp("raddr2", {27'd0, rf_raddr2}, {27'd0, iw[24:20]});
        if (if_ready && !do_flush) sb_q.push_back(v);
        @(posedge clk); #1;
        if_valid = 1'b0; wb_we = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        //            pc         instr         rd1          rd2          we  wa     wd           e_rs1v       e_rs2v       e_imm        rd     op        chk  ctrl
        vecs[0]  = mk(32'h1000, 32'hFFF00293, 32'h1111,    32'h2222,    0, 5'd0,  32'h0,       32'h0,       32'h2222,    32'hFFFFFFFF, 5'd5, ALU_ADD,  1, 7'b1000010);
        vecs[1]  = mk(32'h1004, 32'h002081B3, 32'h7,       32'h9999,    1, 5'd2,  32'h55,      32'h7,       32'h55,      32'h0,        5'd3, ALU_ADD,  1, 7'b1000000);
        vecs[2]  = mk(32'h1008, 32'hFE208CE3, 32'hA,       32'hB,       1, 5'd5,  32'hFF,      32'hA,       32'hB,       32'hFFFFFFF8, 5'd0, ALU_SUB,  1, 7'b0001000);
        vecs[3]  = mk(32'h100C, 32'hFE20AE23, 32'h100,     32'h200,     0, 5'd0,  32'h0,       32'h100,     32'h200,     32'hFFFFFFFC, 5'd0, ALU_ADD,  1, 7'b0010010);
        vecs[4]  = mk(32'h1010, 32'hFF1FF0EF, 32'h31,      32'h17,      0, 5'd0,  32'h0,       32'h31,      32'h17,      32'hFFFFFFF0, 5'd1, ALU_ADD,  1, 7'b1000100);
        vecs[5]  = mk(32'h1014, 32'h123453B7, 32'h8,       32'h3,       1, 5'd3,  32'h333,     32'h8,       32'h333,     32'h12345000, 5'd7, ALU_ADD,  1, 7'b1000010);
        vecs[6]  = mk(32'h1018, 32'h00802203, 32'h1234,    32'h88,      1, 5'd0,  32'hDEAD,    32'h0,       32'h88,      32'h8,        5'd4, ALU_ADD,  1, 7'b1100010);
        vecs[7]  = mk(32'h101C, 32'h00000013, 32'h5,       32'h6,       0, 5'd0,  32'h0,       32'h0,       32'h0,       32'h0,        5'd0, ALU_ADD,  1, 7'b0000010);
        vecs[8]  = mk(32'h1020, 32'h4032D313, 32'h80000000, 32'h3,      0, 5'd0,  32'h0,       32'h80000000, 32'h3,      32'h403,      5'd6, ALU_SRA,  1, 7'b1000010);
        vecs[9]  = mk(32'h1024, 32'h4232D313, 32'h80000000, 32'h3,      0, 5'd0,  32'h0,       32'h80000000, 32'h3,      32'h423,      5'd6, ALU_ADD,  0, 7'b0000011);
        vecs[10] = mk(32'h1028, 32'h00000000, 32'h1,       32'h2,       0, 5'd0,  32'h0,       32'h0,       32'h0,       32'h0,        5'd0, ALU_ADD,  0, 7'b0000001);
`ifdef DECODE_RV32M_EN
        vecs[11] = mk(32'h102C, 32'h023100B3, 32'h22,      32'h33,      1, 5'd2,  32'h44,      32'h44,      32'h33,      32'h0,        5'd1, ALU_MUL,  1, 7'b1000000);
`else
        vecs[11] = mk(32'h102C, 32'h023100B3, 32'h22,      32'h33,      1, 5'd2,  32'h44,      32'h44,      32'h33,      32'h0,        5'd1, ALU_ADD,  0, 7'b0000001);
`endif
        vecs[12] = mk(32'h1030, 32'h402081B3, 32'h11,      32'h12,      1, 5'd1,  32'h77,      32'h77,      32'h12,      32'h0,        5'd3, ALU_SUB,  1, 7'b1000000);

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        id_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;

        // Reset state
        cmp("rst.valid", {31'd0, id_valid}, 32'd0);
        cmp("rst.pc", id_pc, RST_PC);
        cmp("rst.if_ready", {31'd0, if_ready}, 32'd1);
        cmp("rst.imm", id_imm, 32'd0);
        cmp("rst.ctrl", {25'd0, ctrl_now()}, 32'd0);

        // Table-driven: each record captured, checked, then drained with no new valid
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i], 1'b0);
            if (id_valid) check_head($sformatf("vec%0d", i));
            else cmp($sformatf("vec%0d.valid", i), {31'd0, id_valid}, 32'd1);
            tick();
            cmp($sformatf("vec%0d.drain", i), {31'd0, id_valid}, 32'd0);
        end

        // Hold for 3 cycles with a writeback to x1 during the hold
        drive(mk(32'h200, 32'h002081B3, 32'h7, 32'h9, 0, 5'd0, 32'h0,
                 32'hABCD, 32'h9, 32'h0, 5'd3, ALU_ADD, 1, 7'b1000000), 1'b0);
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h300; if_instr = 32'h123453B7;
        #1;
        cmp("hold.if_ready", {31'd0, if_ready}, 32'd0);
        tick();
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'hABCD;
        tick();
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hBAD0;
        tick();
        wb_we = 1'b0;
        cmp("hold.if_ready2", {31'd0, if_ready}, 32'd0);
        check_head("hold");
        if_valid = 1'b0;
        id_ready = 1'b1;
        tick();
        cmp("hold.release", {31'd0, id_valid}, 32'd0);

        // Flush with an incoming instruction: dropped
        drive(vecs[0], 1'b1);
        cmp("flush.in.valid", {31'd0, id_valid}, 32'd0);

        // Flush while holding a valid instruction
        drive(vecs[1], 1'b0);
        id_ready = 1'b0;
        check_head("flush.held");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cmp("flush.held.valid", {31'd0, id_valid}, 32'd0);
        id_ready = 1'b1;

        // Reset in the middle of a hold
        drive(vecs[4], 1'b0);
        id_ready = 1'b0;
        tick();
        void'(sb_q.pop_front());
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("rst.hold.valid", {31'd0, id_valid}, 32'd0);
        cmp("rst.hold.pc", id_pc, RST_PC);
        cmp("rst.hold.rs1_val", id_rs1_val, 32'd0);
        cmp("rst.hold.rs2_val", id_rs2_val, 32'd0);
        cmp("rst.hold.imm", id_imm, 32'd0);
        cmp("rst.hold.regs", {17'd0, id_rs1, id_rs2, id_rd}, 32'd0);
        cmp("rst.hold.ctrl", {20'd0, id_alu_op, ctrl_now()}, 32'd0);
        cmp("rst.hold.if_ready", {31'd0, if_ready}, 32'd1);
        id_ready = 1'b1;

        cmp("sb.empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
